mdu_div_iter: RTL and testbench

- Parametrised iterative integer divider for the backend MDU. Executes RISC-V DIV/DIVU/REM/REMU.
- Radix-2^BITS_PER_CYCLE restoring division with a valid/ready request and response handshake.
- Handles divide-by-zero and signed-overflow fast paths, supports pipeline flush, and keeps a last-result cache so a REM following a DIV (or the reverse) on the same operands completes in one cycle.

---
 rtl/mdu_div_iter.sv | 225 ++++++++++++++++++++++
 tb/tb_mdu_div_iter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: iterative restoring divider for RISC-V DIV/DIVU/REM/REMU, radix 2^BITS_PER_CYCLE.
// Latency: 1 cycle on a last-result cache hit, 2 for divide-by-zero / signed overflow, else XLEN/BITS_PER_CYCLE+3.
// Backpressure: one op in flight; req_ready only in IDLE; the result is held in DONE until resp_ready.
//
// Ports:
//   clk, rst (sync, active high), flush (abort in-flight op)
//   req_valid/req_ready/req_op/req_rs1/req_rs2 : request handshake, op 00 DIV 01 DIVU 10 REM 11 REMU
//   resp_valid/resp_ready/resp_data            : response handshake, quotient or remainder
//   busy                                       : any state other than IDLE
module mdu_div_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,   // 1, 2 or 4, must divide XLEN
  parameter bit CACHE_EN       = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;           // original operands, kept for sign fixup and cache
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] dvd_q, dvd_d;           // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] dsr_q, dsr_d;           // divisor magnitude
  logic [XLEN:0]   prem_q, prem_d;         // partial remainder, extra bit carries subtraction sign
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;

  logic            cache_valid_q, cache_valid_d;
  logic            cache_signed_q, cache_signed_d;
  logic [XLEN-1:0] cache_rs1_q, cache_rs1_d;
  logic [XLEN-1:0] cache_rs2_q, cache_rs2_d;
  logic [XLEN-1:0] cache_quo_q, cache_quo_d;
  logic [XLEN-1:0] cache_rem_q, cache_rem_d;

  // Iteration datapath: BITS_PER_CYCLE restoring steps chained in one cycle.
  logic [XLEN:0]   r_t;
  logic [XLEN-1:0] a_t;
  logic [XLEN:0]   diff_t;

  always_comb begin
    r_t    = prem_q;
    a_t    = dvd_q;
    diff_t = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      r_t    = {r_t[XLEN-1:0], a_t[XLEN-1]};
      a_t    = {a_t[XLEN-2:0], 1'b0};
      diff_t = r_t - {1'b0, dsr_q};
      // Remainder stays below the divisor, so a clear top bit means the trial fit.
      if (!diff_t[XLEN]) begin
        r_t    = diff_t;
        a_t[0] = 1'b1;
      end
    end
  end

  logic            signed_w;
  logic            neg_quo, neg_rem;
  logic [XLEN-1:0] rs1_abs, rs2_abs;
  logic            accept, hit, cache_wr;
  logic [XLEN-1:0] quo_res, rem_res;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    dvd_d          = dvd_q;
    dsr_d          = dsr_q;
    prem_d         = prem_q;
    cnt_d          = cnt_q;
    resp_data_d    = resp_data_q;
    cache_valid_d  = cache_valid_q;
    cache_signed_d = cache_signed_q;
    cache_rs1_d    = cache_rs1_q;
    cache_rs2_d    = cache_rs2_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;
    cache_wr       = 1'b0;
    quo_res        = '0;
    rem_res        = '0;

    signed_w  = !op_q[0];
    neg_quo   = signed_w && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
    neg_rem   = signed_w && rs1_q[XLEN-1];
    rs1_abs   = (signed_w && rs1_q[XLEN-1]) ? -rs1_q : rs1_q;
    rs2_abs   = (signed_w && rs2_q[XLEN-1]) ? -rs2_q : rs2_q;

    req_ready = (state_q == S_IDLE) && !flush;
    accept    = req_valid && req_ready;
    hit       = CACHE_EN && cache_valid_q && (req_rs1 == cache_rs1_q) &&
                (req_rs2 == cache_rs2_q) && (!req_op[0] == cache_signed_q);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          if (hit) begin
            state_d     = S_DONE;
            resp_data_d = req_op[1] ? cache_rem_q : cache_quo_q;
          end else begin
            state_d = S_PREP;
          end
        end
      end
      S_PREP: begin
        if (rs2_q == '0) begin
          quo_res  = '1;
          rem_res  = rs1_q;
          cache_wr = 1'b1;
          state_d  = S_DONE;
        end else if (signed_w && (rs1_q == SMIN) && (rs2_q == '1)) begin
          quo_res  = rs1_q;
          rem_res  = '0;
          cache_wr = 1'b1;
          state_d  = S_DONE;
        end else begin
          dvd_d   = rs1_abs;
          dsr_d   = rs2_abs;
          prem_d  = '0;
          cnt_d   = CW'(N);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        dvd_d  = a_t;
        prem_d = r_t;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        quo_res  = neg_quo ? -dvd_q : dvd_q;
        rem_res  = neg_rem ? -prem_q[XLEN-1:0] : prem_q[XLEN-1:0];
        cache_wr = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flushed op must leave neither a response nor a cache entry behind.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else if (cache_wr) begin
      resp_data_d    = op_q[1] ? rem_res : quo_res;
      cache_valid_d  = 1'b1;
      cache_signed_d = signed_w;
      cache_rs1_d    = rs1_q;
      cache_rs2_d    = rs2_q;
      cache_quo_d    = quo_res;
      cache_rem_d    = rem_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      dvd_q          <= '0;
      dsr_q          <= '0;
      prem_q         <= '0;
      cnt_q          <= '0;
      resp_data_q    <= '0;
      cache_valid_q  <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_rs1_q    <= '0;
      cache_rs2_q    <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      dvd_q          <= dvd_d;
      dsr_q          <= dsr_d;
      prem_q         <= prem_d;
      cnt_q          <= cnt_d;
      resp_data_q    <= resp_data_d;
      cache_valid_q  <= cache_valid_d;
      cache_signed_q <= cache_signed_d;
      cache_rs1_q    <= cache_rs1_d;
      cache_rs2_q    <= cache_rs2_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
    end
  end

  assign resp_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mdu_div_iter.sv
// tb_mdu_div_iter: checks mdu_div_iter (radix 2 and radix 16 instances) against an arithmetic model.
// Latency: model predicts response latency from cache/fast-path rules and checks it per op.
// Backpressure: random resp_ready stalls; resp_valid/resp_data checked stable while stalled.
module tb_mdu_div_iter;

  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, resp_ready, sel;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;

  logic        rr1, rv1, busy1, rr4, rv4, busy4;
  logic [31:0] rd1, rd4;
  logic        m_req_ready, m_resp_valid, m_busy;
  logic [31:0] m_resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Model cache state per instance (0: radix 2, 1: radix 16).
  logic        mc_valid [2];
  logic        mc_sgn   [2];
  logic [31:0] mc_rs1   [2];
  logic [31:0] mc_rs2   [2];

  always #5 clk = ~clk;

  mdu_div_iter #(.XLEN(32), .BITS_PER_CYCLE(1), .CACHE_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid & ~sel), .req_ready(rr1),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(rv1), .resp_ready(resp_ready & ~sel), .resp_data(rd1), .busy(busy1)
  );

  mdu_div_iter #(.XLEN(32), .BITS_PER_CYCLE(4), .CACHE_EN(1'b1)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid & sel), .req_ready(rr4),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(rv4), .resp_ready(resp_ready & sel), .resp_data(rd4), .busy(busy4)
  );

  assign m_req_ready  = sel ? rr4   : rr1;
  assign m_resp_valid = sel ? rv4   : rv1;
  assign m_resp_data  = sel ? rd4   : rd1;
  assign m_busy       = sel ? busy4 : busy1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a RISC-V divide op.
  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic        sgn;
    logic [31:0] q, r;
    sgn = !op[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == SMIN && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic bit model_hit(input logic s, input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    return mc_valid[s] && mc_rs1[s] == a && mc_rs2[s] == b && mc_sgn[s] == !op[0];
  endfunction

  function automatic int model_lat(input logic s, input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (model_hit(s, op, a, b)) return 1;
    if (b == 32'd0 || (!op[0] && a == SMIN && b == 32'hFFFF_FFFF)) return 2;
    return (s ? 8 : 32) + 3;
  endfunction

  // Issue one request, measure latency from acceptance, check data, stall, then hand off.
  task automatic run_op(input logic s, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall,
                        input bit use_lit, input logic [31:0] lit_data, input int lit_lat);
    int          lat, t;
    int          e_lat;
    logic [31:0] e_data;
    bit          was_hit;
    e_lat   = model_lat(s, op, a, b);
    e_data  = model_res(op, a, b);
    was_hit = model_hit(s, op, a, b);
    if (use_lit) begin
      chk("model_pin_data", e_data, lit_data);
      chk("model_pin_lat", e_lat, lit_lat);
    end
    @(negedge clk);
    sel       = s;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_valid = 1'b1;
    #1;
    t = 0;
    while (!m_req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_before_accept", m_req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_accept", m_busy, 1'b1);
    lat = 1;
    while (!m_resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, e_lat);
    chk("resp_data", m_resp_data, e_data);
    resp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", m_resp_valid, 1'b1);
      chk("stall_data", m_resp_data, e_data);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("valid_drop", m_resp_valid, 1'b0);
    chk("data_hold", m_resp_data, e_data);
    if (!was_hit) begin
      mc_valid[s] = 1'b1;
      mc_sgn[s]   = !op[0];
      mc_rs1[s]   = a;
      mc_rs2[s]   = b;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return SMIN;
      4:       return $urandom_range(0, 20);
      5:       return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic random_ops(input logic s, input int count);
    logic [31:0] a, b;
    a = pick_operand();
    b = pick_operand();
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        a = pick_operand();
        b = pick_operand();
      end
      run_op(s, 2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3), 1'b0, 32'd0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    sel        = 1'b0;
    req_op     = 2'b00;
    req_rs1    = 32'd0;
    req_rs2    = 32'd0;
    for (int i = 0; i < 2; i++) mc_valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_resp_valid", rv1, 1'b0);
    chk("reset_busy", busy1, 1'b0);
    chk("reset_resp_data", rd1, 32'd0);
    chk("reset_req_ready", rr1, 1'b1);
    chk("reset_req_ready4", rr4, 1'b1);

    // Directed sequence with hand-derived expectations.
    run_op(1'b0, 2'b01, 32'd100, 32'd7, 0, 1'b1, 32'd14, 35);
    run_op(1'b0, 2'b11, 32'd100, 32'd7, 0, 1'b1, 32'd2, 1);
    run_op(1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2, 1, 1'b1, 32'hFFFF_FFFD, 35);
    run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFF, 1);
    run_op(1'b0, 2'b01, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'h7FFF_FFFC, 35);
    run_op(1'b0, 2'b00, 32'd5, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, 2);
    run_op(1'b0, 2'b11, 32'd5, 32'd0, 0, 1'b1, 32'd5, 2);
    run_op(1'b0, 2'b00, SMIN, 32'hFFFF_FFFF, 0, 1'b1, SMIN, 2);
    run_op(1'b0, 2'b10, SMIN, 32'hFFFF_FFFF, 0, 1'b1, 32'd0, 1);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_idle_req_ready", rr1, 1'b0);
    @(negedge clk);
    flush = 1'b0;

    // Flush during the 10th ITER cycle of DIVU 1000/3.
    sel = 1'b0; req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_flush", busy1, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", busy1, 1'b0);
    chk("flush_resp_valid", rv1, 1'b0);
    flush = 1'b0;
    #1;
    chk("flush_req_ready", rr1, 1'b1);
    t = 0;
    repeat (40) begin
      @(negedge clk);
      if (rv1) t++;
    end
    chk("flush_no_response", t, 0);
    run_op(1'b0, 2'b11, 32'd1000, 32'd3, 5, 1'b1, 32'd1, 35);

    // Reset mid-ITER, then a repeat of the last completed request must miss.
    @(negedge clk);
    sel = 1'b0; req_op = 2'b01; req_rs1 = 32'd100; req_rs2 = 32'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_resp_valid", rv1, 1'b0);
    chk("rst_mid_busy", busy1, 1'b0);
    chk("rst_mid_resp_data", rd1, 32'd0);
    chk("rst_mid_req_ready", rr1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) mc_valid[i] = 1'b0;
    run_op(1'b0, 2'b11, 32'd1000, 32'd3, 0, 1'b1, 32'd1, 35);

    // Radix-16 instance.
    run_op(1'b1, 2'b01, 32'd100, 32'd7, 0, 1'b1, 32'd14, 11);
    run_op(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 2, 1'b1, 32'hFFFF_FFFF, 11);

    random_ops(1'b0, 30);
    random_ops(1'b1, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
